// File: rtl/down_count_monitor.sv
// ---------------------------------------------------------------------------
// down_count_monitor
//
// Watches the output of a down counter. The count may only hold or step down
// by one (mod 2^WIDTH). Illegal steps are flagged and latched, and a 0 -> max
// underflow wrap is counted. Every output is registered.
//
// Optional build macro:
//   DCM_WRAP_SAT_EN  wrap_count saturates at all-ones and raises wrap_sat.
//                    When undefined, wrap_count rolls over and wrap_sat is 0.
//
// Ports:
//   CLK         in   1            clock, rising edge
//   Reset       in   1            asynchronous reset, active low
//   en          in   1            monitor enable
//   clear       in   1            sync clear of wrap_count, err_sticky, FAULT
//   count_in    in   WIDTH        monitored counter value (synchronous to CLK)
//   wrap_pulse  out  1            one-cycle pulse per 0 -> max wrap
//   step_err    out  1            one-cycle pulse per illegal step
//   err_sticky  out  1            latched error, cleared by clear/reset
//   wrap_count  out  WRAP_CNT_W   number of wraps seen
//   wrap_sat    out  1            wrap_count saturated (saturating build only)
//   state       out  2            IDLE=00 ARM=01 TRACK=10 FAULT=11
//
// state | meaning
// IDLE  | disabled, nothing sampled
// ARM   | first sample captured, next sample is compared
// TRACK | comparing each sample against the previous one
// FAULT | illegal step seen, compares frozen until clear/reset
// ---------------------------------------------------------------------------
module down_count_monitor #(
    parameter int WIDTH      = 4,
    parameter int WRAP_CNT_W = 8
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  en,
    input  logic                  clear,
    input  logic [WIDTH-1:0]      count_in,
    output logic                  wrap_pulse,
    output logic                  step_err,
    output logic                  err_sticky,
    output logic [WRAP_CNT_W-1:0] wrap_count,
    output logic                  wrap_sat,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARM   = 2'b01,
        TRACK = 2'b10,
        FAULT = 2'b11
    } state_t;

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        last_q, last_d;
    logic [WRAP_CNT_W-1:0]   wc_q, wc_d;
    logic                    sticky_q, sticky_d;
    logic                    wrap_q, wrap_d;
    logic                    err_q, err_d;

    logic [WIDTH-1:0]        last_dec;
    logic                    step_legal;
    logic                    step_wrap;

    assign last_dec   = last_q - 1'b1;
    assign step_legal = (count_in == last_q) || (count_in == last_dec);
    assign step_wrap  = (last_q == '0) && (count_in == '1);

`ifdef DCM_WRAP_SAT_EN
    logic sat_q, sat_d;
    assign wrap_sat = sat_q;
`else
    assign wrap_sat = 1'b0;
`endif

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            last_q   <= '0;
            wc_q     <= '0;
            sticky_q <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef DCM_WRAP_SAT_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            wc_q     <= wc_d;
            sticky_q <= sticky_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
`ifdef DCM_WRAP_SAT_EN
            sat_q    <= sat_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        wc_d     = wc_q;
        sticky_d = sticky_q;
        wrap_d   = 1'b0;
        err_d    = 1'b0;
`ifdef DCM_WRAP_SAT_EN
        sat_d    = sat_q;
`endif

        if (clear) begin
            wc_d     = '0;
            sticky_d = 1'b0;
`ifdef DCM_WRAP_SAT_EN
            sat_d    = 1'b0;
`endif
            // Capture here even when leaving FAULT so the ARM compare that
            // follows works against a fresh sample rather than a frozen one.
            if (en) begin
                state_d = ARM;
                last_d  = count_in;
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_d = ARM;
                        last_d  = count_in;
                    end
                end
                ARM, TRACK: begin
                    if (!en) begin
                        state_d = IDLE;
                    end else begin
                        last_d = count_in;
                        if (step_legal) begin
                            state_d = TRACK;
                            if (step_wrap) begin
                                wrap_d = 1'b1;
`ifdef DCM_WRAP_SAT_EN
                                if (wc_q == '1) begin
                                    sat_d = 1'b1;
                                end else begin
                                    wc_d = wc_q + 1'b1;
                                end
`else
                                wc_d = wc_q + 1'b1;
`endif
                            end
                        end else begin
                            state_d  = FAULT;
                            err_d    = 1'b1;
                            sticky_d = 1'b1;
                        end
                    end
                end
                default: begin
                    // FAULT: everything frozen until clear or reset
                end
            endcase
        end
    end

    assign wrap_pulse = wrap_q;
    assign step_err   = err_q;
    assign err_sticky = sticky_q;
    assign wrap_count = wc_q;
    assign state      = state_q;

endmodule
